// File: rtl/sc_stream_decoder.sv
// sc_stream_decoder: stochastic-to-binary decoder.
// Counts the ones in a STREAM_LEN-bit unipolar stochastic stream that arrives
// under a valid/ready handshake. The count is then normalized with a
// leading-one detect, and count, mantissa (hidden one removed) and shift are
// presented under a second valid/ready handshake.
// Optional feature: define SC_DEC_BIPOLAR_EN to add the bipolar_val output
// (2*count - STREAM_LEN, signed).
module sc_stream_decoder #(
    parameter int WIDTH      = 8,
    parameter int STREAM_LEN = 255,
    parameter int MANT_W     = 7,
    localparam int SHIFT_W   = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               bit_valid,
    input  logic               bit_in,
    output logic               bit_ready,
    output logic               busy,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   count,
    output logic [MANT_W-1:0]  norm_mant,
    output logic [SHIFT_W-1:0] norm_shift,
`ifdef SC_DEC_BIPOLAR_EN
    output logic               zero,
    output logic signed [WIDTH:0] bipolar_val
`else
    output logic               zero
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_NORM,
        S_DONE
    } state_e;

    localparam logic [WIDTH-1:0] LAST_IDX = WIDTH'(STREAM_LEN - 1);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]   count_q, count_d;
    logic [MANT_W-1:0]  mant_q, mant_d;
    logic [SHIFT_W-1:0] shift_q, shift_d;
    logic               zero_q, zero_d;
    logic               out_valid_q, out_valid_d;
`ifdef SC_DEC_BIPOLAR_EN
    logic signed [WIDTH:0] bip_q, bip_d;
`endif

    logic [SHIFT_W-1:0] lod_pos;
    logic [SHIFT_W-1:0] lod_shift;
    logic [WIDTH-1:0]   shifted;

    // Leading-one detect on the accumulator and the normalizing left shift.
    always_comb begin
        // NOTE: every combinationally assigned signal gets a default first, so
        // no path through the block leaves it unassigned and a latch is inferred.
        lod_pos = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (acc_q[i]) begin
                lod_pos = SHIFT_W'(i);
            end
        end
        lod_shift = SHIFT_W'(WIDTH - 1) - lod_pos;
        // With a nonzero accumulator the MSB of the shifted value is the hidden one.
        shifted   = acc_q << lod_shift;
    end

    // Next-state and datapath update for the conversion FSM.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        idx_d       = idx_q;
        count_d     = count_q;
        mant_d      = mant_q;
        shift_d     = shift_q;
        zero_d      = zero_q;
        out_valid_d = 1'b0;
`ifdef SC_DEC_BIPOLAR_EN
        bip_d       = bip_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    acc_d   = '0;
                    idx_d   = '0;
                    state_d = S_ACCUM;
                end
            end
            S_ACCUM: begin
                // bit_ready is high throughout ACCUM, so bit_valid alone accepts.
                if (bit_valid) begin
                    acc_d = acc_q + {{(WIDTH-1){1'b0}}, bit_in};
                    idx_d = idx_q + WIDTH'(1);
                    if (idx_q == LAST_IDX) begin
                        state_d = S_NORM;
                    end
                end
            end
            S_NORM: begin
                count_d = acc_q;
                zero_d  = ~shifted[WIDTH-1];
                shift_d = shifted[WIDTH-1] ? lod_shift : '0;
                mant_d  = shifted[WIDTH-1] ? shifted[MANT_W-1:0] : '0;
`ifdef SC_DEC_BIPOLAR_EN
                // Modulo-2^(WIDTH+1) arithmetic yields the two's-complement result.
                bip_d   = {acc_q, 1'b0} - (WIDTH+1)'(STREAM_LEN);
`endif
                state_d = S_DONE;
            end
            S_DONE: begin
                // out_valid is registered: it rises one cycle after entering DONE
                // and the handshake is only honoured once it is visible.
                if (out_valid_q && out_ready) begin
                    state_d = S_IDLE;
                end else begin
                    out_valid_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and result registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values, independent of statement order.
        if (!rst) begin
            state_q     <= S_IDLE;
            acc_q       <= '0;
            idx_q       <= '0;
            count_q     <= '0;
            mant_q      <= '0;
            shift_q     <= '0;
            zero_q      <= 1'b0;
            out_valid_q <= 1'b0;
`ifdef SC_DEC_BIPOLAR_EN
            bip_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            idx_q       <= idx_d;
            count_q     <= count_d;
            mant_q      <= mant_d;
            shift_q     <= shift_d;
            zero_q      <= zero_d;
            out_valid_q <= out_valid_d;
`ifdef SC_DEC_BIPOLAR_EN
            bip_q       <= bip_d;
`endif
        end
    end

    assign bit_ready  = (state_q == S_ACCUM);
    assign busy       = (state_q != S_IDLE);
    assign out_valid  = out_valid_q;
    assign count      = count_q;
    assign norm_mant  = mant_q;
    assign norm_shift = shift_q;
    assign zero       = zero_q;
`ifdef SC_DEC_BIPOLAR_EN
    assign bipolar_val = bip_q;
`endif

endmodule

// File: tb/tb_sc_stream_decoder.sv
// Self-checking bench for sc_stream_decoder (default parameters).
// Table of conversions plus a hand-written reset-during-stream sequence;
// expected results are queued at start and compared at the output handshake.
module tb_sc_stream_decoder;

    localparam int WIDTH  = 8;
    localparam int SLEN   = 255;
    localparam int MANT_W = 7;
    localparam int SH_W   = 3;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic              bit_valid = 1'b0;
    logic              bit_in = 1'b0;
    logic              bit_ready;
    logic              busy;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [WIDTH-1:0]  count;
    logic [MANT_W-1:0] norm_mant;
    logic [SH_W-1:0]   norm_shift;
    logic              zero;
`ifdef SC_DEC_BIPOLAR_EN
    logic signed [WIDTH:0] bipolar_val;
`endif

    sc_stream_decoder dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .bit_valid  (bit_valid),
        .bit_in     (bit_in),
        .bit_ready  (bit_ready),
        .busy       (busy),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .count      (count),
        .norm_mant  (norm_mant),
        .norm_shift (norm_shift),
`ifdef SC_DEC_BIPOLAR_EN
        .zero       (zero),
        .bipolar_val(bipolar_val)
`else
        .zero       (zero)
`endif
    );

    always #5 clk = ~clk;

    // kind 0: first n bits are ones; kind 1: a one at every 4th bit.
    typedef struct {
        string            name;
        int               kind;
        int               n;
        bit               toggle;
        int               hold;
        bit               xstart;
        logic [WIDTH-1:0] c;
        logic [SH_W-1:0]  sh;
        logic [MANT_W-1:0] m;
        logic             z;
    } vec_t;

    typedef struct {
        logic [WIDTH-1:0]  c;
        logic [SH_W-1:0]   sh;
        logic [MANT_W-1:0] m;
        logic              z;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic signed [31:0] act,
                         input logic signed [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic stream_bit(input int kind, input int n, input int i);
        if (kind == 0) return (i < n);
        return (i % 4 == 0);
    endfunction

    task automatic run_conv(input vec_t v);
        exp_t e;
        exp_t got;
        int   lat;
        bit   rdy_ok;
        bit   stable;
        logic [WIDTH-1:0]  s_c;
        logic [SH_W-1:0]   s_sh;
        logic [MANT_W-1:0] s_m;
        logic              s_z;

        e.c = v.c; e.sh = v.sh; e.m = v.m; e.z = v.z;
        start = 1'b1;
        tick();
        start = 1'b0;
        check({v.name, "_busy_start"}, busy, 1);
        exp_q.push_back(e);

        rdy_ok = 1'b1;
        for (int i = 0; i < SLEN; i++) begin
            if (v.toggle) begin
                // Stall cycle: a one on bit_in must not be counted.
                bit_valid = 1'b0;
                bit_in    = 1'b1;
                if (bit_ready !== 1'b1) rdy_ok = 1'b0;
                tick();
            end
            bit_valid = 1'b1;
            bit_in    = stream_bit(v.kind, v.n, i);
            if (v.xstart && i == 50) start = 1'b1;
            if (bit_ready !== 1'b1) rdy_ok = 1'b0;
            tick();
            start = 1'b0;
        end
        bit_valid = 1'b0;
        bit_in    = 1'b0;
        check({v.name, "_bit_ready_accum"}, rdy_ok, 1);
        check({v.name, "_bit_ready_after_last"}, bit_ready, 0);

        lat = 0;
        while (out_valid !== 1'b1 && lat < 10) begin
            tick();
            lat++;
        end
        check({v.name, "_latency"}, lat, 2);

        s_c = count; s_sh = norm_shift; s_m = norm_mant; s_z = zero;
        stable = 1'b1;
        for (int h = 0; h < v.hold; h++) begin
            out_ready = 1'b0;
            if (v.xstart && h == 1) start = 1'b1;
            tick();
            start = 1'b0;
            if (out_valid !== 1'b1 || count !== s_c || norm_shift !== s_sh ||
                norm_mant !== s_m || zero !== s_z) stable = 1'b0;
        end
        if (v.hold > 0) check({v.name, "_stable_hold"}, stable, 1);

        out_ready = 1'b1;
        if (v.xstart) start = 1'b1;
        if (exp_q.size() == 0) begin
            check({v.name, "_queue_empty"}, 1, 0);
        end else begin
            got = exp_q.pop_front();
            check({v.name, "_count"}, count, got.c);
            check({v.name, "_zero"}, zero, got.z);
            check({v.name, "_norm_shift"}, norm_shift, got.sh);
            check({v.name, "_norm_mant"}, norm_mant, got.m);
`ifdef SC_DEC_BIPOLAR_EN
            check({v.name, "_bipolar"}, bipolar_val, 2 * int'(got.c) - SLEN);
`endif
        end
        tick();
        out_ready = 1'b0;
        start     = 1'b0;
        check({v.name, "_out_valid_drop"}, out_valid, 0);
        check({v.name, "_idle_after_ack"}, busy, 0);
        check({v.name, "_count_retained"}, count, e.c);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_bit_ready"}, bit_ready, 0);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_count"}, count, 0);
        check({tag, "_norm_mant"}, norm_mant, 0);
        check({tag, "_norm_shift"}, norm_shift, 0);
        check({tag, "_zero"}, zero, 0);
`ifdef SC_DEC_BIPOLAR_EN
        check({tag, "_bipolar"}, bipolar_val, 0);
`endif
    endtask

    vec_t vecs[6];

    initial begin
        //        name       kind n    tog hold xs  count  sh    mant   z
        vecs[0] = '{"ones",   0, 255, 0,  0,   0,  8'd255, 3'd0, 7'h7F, 1'b0};
        vecs[1] = '{"zeros",  0, 0,   0,  0,   0,  8'd0,   3'd0, 7'h00, 1'b1};
        vecs[2] = '{"five",   0, 5,   0,  0,   0,  8'd5,   3'd5, 7'h20, 1'b0};
        vecs[3] = '{"spread", 1, 0,   1,  10,  0,  8'd64,  3'd1, 7'h00, 1'b0};
        vecs[4] = '{"xstart", 0, 128, 0,  3,   1,  8'd128, 3'd0, 7'h00, 1'b0};
        vecs[5] = '{"hundred",0, 100, 0,  2,   0,  8'd100, 3'd1, 7'h48, 1'b0};

        rst = 1'b0;
        tick();
        tick();
        check_all_zero("reset");
        rst = 1'b1;
        tick();

        foreach (vecs[k]) run_conv(vecs[k]);

        // Reset in the middle of a stream discards the partial conversion.
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 100; i++) begin
            bit_valid = 1'b1;
            bit_in    = 1'b1;
            tick();
        end
        bit_valid = 1'b0;
        rst = 1'b0;
        tick();
        check_all_zero("midreset");
        rst = 1'b1;
        bit_valid = 1'b1;
        tick();
        tick();
        check("midreset_idle_no_ready", bit_ready, 0);
        bit_valid = 1'b0;
        run_conv('{"three", 0, 3, 0, 1, 0, 8'd3, 3'd6, 7'h40, 1'b0});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Hard time bound so the run always terminates.
    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
